// File: rtl/data_check.sv
// AXI-stream sink that throttles in_ready with a rotating pattern and checks each
// accepted beat against an arithmetic sequence, frame length and AXI hold rules.
module data_check #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    SAMPLES_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] DATA_START    = 32'h04030201,
  parameter logic [DATA_WIDTH-1:0] DATA_STEP     = 32'h01010101,
  parameter int                    NUM_SAMPLES   = 10,
  parameter logic [7:0]            READY_PATTERN = 8'b1111_1111,
  parameter int                    ERR_WIDTH     = 16,
  parameter int                    TIMEOUT       = 1000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_enable,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [SAMPLES_WIDTH-1:0] num_samples,
  output logic [ERR_WIDTH-1:0]     num_errors,
  output logic [SAMPLES_WIDTH-1:0] first_err_sample,
  output logic                     done,
  output logic                     error,
  output logic                     timeout
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DONE = 2'd1,
    ST_TOUT = 2'd2
  } state_t;

  localparam logic [SAMPLES_WIDTH-1:0] LAST_IDX    = SAMPLES_WIDTH'(NUM_SAMPLES - 1);
  localparam logic [31:0]              TIMEOUT_VAL = 32'(TIMEOUT);
  localparam logic                     TOUT_EN     = (TIMEOUT != 0);
  localparam logic [ERR_WIDTH-1:0]     ERR_MAX     = {ERR_WIDTH{1'b1}};

  state_t                   state_r;
  logic [7:0]               pattern_r;
  logic [DATA_WIDTH-1:0]    expected_r;
  logic [31:0]              idle_r;
  logic [SAMPLES_WIDTH-1:0] num_samples_r;
  logic [ERR_WIDTH-1:0]     num_errors_r;
  logic [SAMPLES_WIDTH-1:0] first_err_r;
  logic                     done_r;
  logic                     error_r;
  logic                     timeout_r;
  logic                     overrun_seen_r;
  logic                     hold_pend_r;
  logic [DATA_WIDTH-1:0]    hold_data_r;
  logic                     hold_last_r;

  logic                     ready_s;
  logic                     accept_s;
  logic                     last_beat_s;
  logic                     data_err_s;
  logic                     last_err_s;
  logic                     hold_err_s;
  logic                     overrun_err_s;
  logic                     tout_hit_s;
  logic [1:0]               err_inc_s;
  logic [ERR_WIDTH:0]       err_sum_s;
  logic [ERR_WIDTH-1:0]     err_next_s;

  // Handshake and per-cycle check results, all derived from registers and inputs
  always_comb begin
    ready_s       = in_enable & (state_r == ST_RUN) & pattern_r[0];
    accept_s      = in_valid & ready_s;
    last_beat_s   = (num_samples_r == LAST_IDX);
    data_err_s    = accept_s & (in_data != expected_r);
    last_err_s    = accept_s & (in_last != last_beat_s);
    // A beat offered but not taken last cycle must be re-offered unchanged
    hold_err_s    = hold_pend_r & (state_r == ST_RUN) &
                    (~in_valid | (in_data != hold_data_r) | (in_last != hold_last_r));
    overrun_err_s = (state_r == ST_DONE) & in_valid & ~overrun_seen_r;
    tout_hit_s    = TOUT_EN & (state_r == ST_RUN) & in_enable & ~accept_s &
                    ((idle_r + 32'd1) == TIMEOUT_VAL);
    err_inc_s     = {1'b0, data_err_s} + {1'b0, last_err_s} +
                    {1'b0, hold_err_s} + {1'b0, overrun_err_s};
    err_sum_s     = {1'b0, num_errors_r} + (ERR_WIDTH+1)'(err_inc_s);
    if (err_sum_s > {1'b0, ERR_MAX}) begin
      err_next_s = ERR_MAX;
    end else begin
      err_next_s = err_sum_s[ERR_WIDTH-1:0];
    end
  end

  // Checker state machine, counters and sticky status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_RUN;
      pattern_r      <= READY_PATTERN;
      expected_r     <= DATA_START;
      idle_r         <= 32'd0;
      num_samples_r  <= {SAMPLES_WIDTH{1'b0}};
      num_errors_r   <= {ERR_WIDTH{1'b0}};
      first_err_r    <= {SAMPLES_WIDTH{1'b1}};
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      timeout_r      <= 1'b0;
      overrun_seen_r <= 1'b0;
      hold_pend_r    <= 1'b0;
      hold_data_r    <= {DATA_WIDTH{1'b0}};
      hold_last_r    <= 1'b0;
    end else begin
      num_errors_r <= err_next_s;
      error_r      <= |err_next_s;
      // Hold errors are attributed to the beat still waiting, i.e. num_samples
      if ((num_errors_r == {ERR_WIDTH{1'b0}}) && (err_inc_s != 2'd0)) begin
        first_err_r <= num_samples_r;
      end
      if (overrun_err_s) begin
        overrun_seen_r <= 1'b1;
      end
      hold_pend_r <= (state_r == ST_RUN) & in_valid & ~accept_s;
      hold_data_r <= in_data;
      hold_last_r <= in_last;

      case (state_r)
        ST_RUN: begin
          pattern_r <= {pattern_r[0], pattern_r[7:1]};
          if (accept_s) begin
            expected_r    <= expected_r + DATA_STEP;
            num_samples_r <= num_samples_r + {{(SAMPLES_WIDTH-1){1'b0}}, 1'b1};
            idle_r        <= 32'd0;
            if (last_beat_s) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end else if (tout_hit_s) begin
            state_r   <= ST_TOUT;
            timeout_r <= 1'b1;
            idle_r    <= idle_r + 32'd1;
          end else if (in_enable) begin
            idle_r <= idle_r + 32'd1;
          end
        end
        ST_DONE, ST_TOUT: begin
          state_r <= state_r;
        end
        default: begin
          state_r <= ST_TOUT;
        end
      endcase
    end
  end

  assign in_ready         = ready_s;
  assign num_samples      = num_samples_r;
  assign num_errors       = num_errors_r;
  assign first_err_sample = first_err_r;
  assign done             = done_r;
  assign error            = error_r;
  assign timeout          = timeout_r;

endmodule
